// File: rtl/vmac_seq.sv
// vmac_seq: beat-sequencing controller wrapped around an external combinational vector_mac.
// Build option VMAC_SEQ_OPREG_EN registers operands and accumulates in a separate WAIT cycle.
`default_nettype none

module vmac_seq #(
    parameter int E_WIDTH = 8,
    parameter int M_WIDTH = 23,
    parameter int I_WIDTH = 1 + E_WIDTH + M_WIDTH,
    parameter int VECTOR  = 4,
    parameter int LEN_W   = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_i,
    input  logic [LEN_W-1:0]                len_i,
    input  logic [VECTOR-1:0][I_WIDTH-1:0]  c_init_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [VECTOR-1:0][I_WIDTH-1:0]  a_in_i,
    input  logic [VECTOR-1:0][I_WIDTH-1:0]  b_in_i,
    output logic [VECTOR-1:0][I_WIDTH-1:0]  mac_a_o,
    output logic [VECTOR-1:0][I_WIDTH-1:0]  mac_b_o,
    output logic [VECTOR-1:0][I_WIDTH-1:0]  mac_c_o,
    input  logic [VECTOR-1:0][I_WIDTH-1:0]  mac_out_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [VECTOR-1:0][I_WIDTH-1:0]  out_o,
    output logic                            busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
`ifdef VMAC_SEQ_OPREG_EN
        S_WAIT = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t                           state_q, state_d;
    logic [VECTOR-1:0][I_WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]                 cnt_q, cnt_d;
`ifdef VMAC_SEQ_OPREG_EN
    logic [VECTOR-1:0][I_WIDTH-1:0]   opa_q, opa_d;
    logic [VECTOR-1:0][I_WIDTH-1:0]   opb_q, opb_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef VMAC_SEQ_OPREG_EN
            opa_q   <= '0;
            opb_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`ifdef VMAC_SEQ_OPREG_EN
            opa_q   <= opa_d;
            opb_q   <= opb_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        mac_a_o     = '0;
        mac_b_o     = '0;
`ifdef VMAC_SEQ_OPREG_EN
        opa_d       = opa_q;
        opb_d       = opb_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    acc_d   = c_init_i;
                    cnt_d   = len_i;
                    state_d = (len_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                in_ready_o = 1'b1;
`ifdef VMAC_SEQ_OPREG_EN
                if (in_valid_i) begin
                    opa_d   = a_in_i;
                    opb_d   = b_in_i;
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = S_WAIT;
                end
`else
                mac_a_o = a_in_i;
                mac_b_o = b_in_i;
                if (in_valid_i) begin
                    acc_d = mac_out_i;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
`endif
            end
`ifdef VMAC_SEQ_OPREG_EN
            // cnt was already decremented by the RUN fire, so zero marks the last beat
            S_WAIT: begin
                mac_a_o = opa_q;
                mac_b_o = opb_q;
                acc_d   = mac_out_i;
                state_d = (cnt_q == '0) ? S_DONE : S_RUN;
            end
`endif
            S_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mac_c_o = acc_q;
    assign out_o   = acc_q;
    assign busy_o  = (state_q != S_IDLE);

endmodule

`default_nettype wire
